imm_encoder: RTL and testbench

IMM_ENCODER -- requirements
Module: imm_encoder

---
 rtl/imm_encoder.sv | 114 +++++++++++
 tb/tb_imm_encoder.sv | 421 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_encoder.sv
// imm_encoder: packs a sign-extended immediate into ImmGen's {instr[31:20], instr[11:7]} field.
// Latency 1 cycle; in_ready = !out_valid || out_ready gives one result per cycle when drained.
// Result is held stable while out_valid && !out_ready. IMMENC_ERRCNT_EN adds a saturating err_count.
module imm_encoder (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_immsel,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [16:0] ImmOUT,
  output logic [16:0] out_mask,
  output logic        out_err
`ifdef IMMENC_ERRCNT_EN
  ,
  output logic [7:0]  err_count
`endif
);

  localparam logic [1:0] SEL_I = 2'b00;
  localparam logic [1:0] SEL_S = 2'b01;
  localparam logic [1:0] SEL_B = 2'b10;

  localparam logic [16:0] MASK_I  = 17'h1FFE0;
  localparam logic [16:0] MASK_SB = 17'h1FC1F;

  logic        out_valid_q;
  logic [16:0] imm_q, imm_d;
  logic [16:0] mask_q, mask_d;
  logic        err_q, err_d;
  logic        fits12;
  logic        fits13;
  logic        accept;

  assign in_ready  = !out_valid_q || out_ready;
  assign accept    = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign ImmOUT    = imm_q;
  assign out_mask  = mask_q;
  assign out_err   = err_q;

  // Range-check the immediate and scatter its bits into the instruction field layout.
  always_comb begin
    // Sign-extension check: all bits above the field's sign bit must match it.
    fits12 = (&in_imm[31:11]) || !(|in_imm[31:11]);
    fits13 = (&in_imm[31:12]) || !(|in_imm[31:12]);
    imm_d  = '0;
    mask_d = '0;
    err_d  = 1'b0;
    case (in_immsel)
      SEL_I: begin
        if (fits12) begin
          imm_d  = {in_imm[11:0], 5'b0};
          mask_d = MASK_I;
        end else begin
          err_d = 1'b1;
        end
      end
      SEL_S: begin
        if (fits12) begin
          imm_d  = {in_imm[11:5], 5'b0, in_imm[4:0]};
          mask_d = MASK_SB;
        end else begin
          err_d = 1'b1;
        end
      end
      SEL_B: begin
        // Branch offsets are halfword aligned; bit 0 is implicit and must be zero.
        if (fits13 && !in_imm[0]) begin
          imm_d  = {in_imm[12], in_imm[10:5], 5'b0, in_imm[4:1], in_imm[11]};
          mask_d = MASK_SB;
        end else begin
          err_d = 1'b1;
        end
      end
      default: err_d = 1'b1;
    endcase
  end

  // Output register: load on accept, drop valid on consumption, otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      imm_q       <= '0;
      mask_q      <= '0;
      err_q       <= 1'b0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      imm_q       <= imm_d;
      mask_q      <= mask_d;
      err_q       <= err_d;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

`ifdef IMMENC_ERRCNT_EN
  logic [7:0] err_count_q;

  assign err_count = err_count_q;

  // Count accepted unencodable requests, saturating at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count_q <= '0;
    end else if (accept && err_d && (err_count_q != 8'hFF)) begin
      err_count_q <= err_count_q + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_imm_encoder.sv
// Bench for imm_encoder: directed spec cases, boundaries, backpressure, reset and a randomized scoreboard.
module tb_imm_encoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  in_immsel = 2'b00;
  logic [31:0] in_imm = 32'h0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [16:0] ImmOUT;
  logic [16:0] out_mask;
  logic        out_err;
`ifdef IMMENC_ERRCNT_EN
  logic [7:0]  err_count;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  // Scoreboard view of the output register and error counter.
  logic        m_vld  = 1'b0;
  logic [16:0] m_imm  = '0;
  logic [16:0] m_mask = '0;
  logic        m_err  = 1'b0;
  int          m_cnt  = 0;

  imm_encoder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_immsel (in_immsel),
    .in_imm    (in_imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ImmOUT    (ImmOUT),
    .out_mask  (out_mask),
    .out_err   (out_err)
`ifdef IMMENC_ERRCNT_EN
    ,
    .err_count (err_count)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  // Reference encoder written from the field rules with integer range tests and shifts.
  function automatic void ref_enc(input logic [1:0] sel, input logic [31:0] imm,
                                  output logic [16:0] e_imm, output logic [16:0] e_mask,
                                  output logic e_err);
    int v;
    bit ok;
    v      = $signed(imm);
    ok     = 1'b0;
    e_imm  = '0;
    e_mask = '0;
    case (sel)
      2'd0: begin
        ok     = (v >= -2048) && (v <= 2047);
        e_imm  = 17'((imm & 32'hFFF) << 5);
        e_mask = 17'h1FFE0;
      end
      2'd1: begin
        ok     = (v >= -2048) && (v <= 2047);
        e_imm  = 17'((((imm >> 5) & 32'h7F) << 10) | (imm & 32'h1F));
        e_mask = 17'h1FC1F;
      end
      2'd2: begin
        ok     = (v >= -4096) && (v <= 4094) && ((v % 2) == 0);
        e_imm  = 17'((((imm >> 12) & 32'h1) << 16) | (((imm >> 5) & 32'h3F) << 10) |
                     (((imm >> 1) & 32'hF) << 1) | ((imm >> 11) & 32'h1));
        e_mask = 17'h1FC1F;
      end
      default: ok = 1'b0;
    endcase
    if (!ok) begin
      e_imm  = '0;
      e_mask = '0;
    end
    e_err = !ok;
  endfunction

  // ImmGen-style decode of the packed field back to a sign-extended value.
  function automatic logic [31:0] decode(input logic [1:0] sel, input logic [16:0] f);
    logic [11:0] s;
    logic [12:0] b;
    s = (sel == 2'd0) ? f[16:5] : {f[16:10], f[4:0]};
    b = {f[16], f[0], f[15:10], f[4:1], 1'b0};
    if (sel == 2'd2) return {{19{b[12]}}, b};
    return {{20{s[11]}}, s};
  endfunction

  function automatic logic [31:0] rand_imm();
    int r;
    case ($urandom_range(0, 3))
      0:       r = int'($urandom);
      1:       r = int'($urandom_range(0, 10000)) - 5000;
      2:       r = int'($urandom_range(0, 5000)) - 2500;
      default: r = int'($urandom_range(0, 8)) - 4 + (($urandom_range(0, 1) == 1) ? 2048 : -4096);
    endcase
    return 32'(r);
  endfunction

  // Present one request with out_ready=1; the result is visible when this returns.
  task automatic send(input logic [1:0] sel, input logic [31:0] imm);
    logic [16:0] ei, em;
    logic ee;
    @(negedge clk);
    in_valid  = 1'b1;
    in_immsel = sel;
    in_imm    = imm;
    out_ready = 1'b1;
    ref_enc(sel, imm, ei, em, ee);
    if (ee && m_cnt < 255) m_cnt++;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    rst_n  = 1'b1;
    m_vld  = 1'b0;
    m_imm  = '0;
    m_mask = '0;
    m_err  = 1'b0;
    m_cnt  = 0;
  endtask

  task automatic test_reset();
    logic [35:0] got;
    #1;
    got = {out_valid, out_err, ImmOUT, out_mask};
    n_checks++;
    if (got !== 36'h0) $display("FAIL reset_outputs: got %h expected %h", got, 36'h0);
    else n_pass++;
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    else n_pass++;
`ifdef IMMENC_ERRCNT_EN
    n_checks++;
    if (err_count !== 8'd0) $display("FAIL reset_err_count: got %0d expected 0", err_count);
    else n_pass++;
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({in_ready, out_valid} !== 2'b10)
      $display("FAIL post_reset_ready_valid: got %b expected 10", {in_ready, out_valid});
    else n_pass++;
  endtask

  task automatic test_directed();
    logic [35:0] got;
    logic [35:0] exp;
    send(2'd0, 32'hFFFF_FFFF);
    got = {out_valid, out_err, ImmOUT, out_mask};
    exp = {1'b1, 1'b0, 17'h1FFE0, 17'h1FFE0};
    n_checks++;
    if (got !== exp) $display("FAIL dir_I_neg1: got %h expected %h", got, exp);
    else n_pass++;
    send(2'd1, 32'h0000_07FF);
    got = {out_valid, out_err, ImmOUT, out_mask};
    exp = {1'b1, 1'b0, 17'h0FC1F, 17'h1FC1F};
    n_checks++;
    if (got !== exp) $display("FAIL dir_S_2047: got %h expected %h", got, exp);
    else n_pass++;
    send(2'd2, 32'hFFFF_F000);
    got = {out_valid, out_err, ImmOUT, out_mask};
    exp = {1'b1, 1'b0, 17'h10000, 17'h1FC1F};
    n_checks++;
    if (got !== exp) $display("FAIL dir_B_m4096: got %h expected %h", got, exp);
    else n_pass++;
    send(2'd2, 32'h0000_0003);
    got = {out_valid, out_err, ImmOUT, out_mask};
    exp = {1'b1, 1'b1, 17'h0, 17'h0};
    n_checks++;
    if (got !== exp) $display("FAIL dir_B_odd: got %h expected %h", got, exp);
    else n_pass++;
`ifdef IMMENC_ERRCNT_EN
    n_checks++;
    if (err_count !== 8'd1) $display("FAIL dir_err_count_inc: got %0d expected 1", err_count);
    else n_pass++;
`endif
  endtask

  task automatic test_boundary();
    logic [1:0]  sels [8] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2};
    logic [31:0] imms [8] = '{32'hFFFF_F800, 32'h0000_07FF, 32'hFFFF_F7FF, 32'hFFFF_F800,
                              32'h0000_0800, 32'h0000_0FFE, 32'h0000_1000, 32'hFFFF_EFFE};
    logic [16:0] ei, em;
    logic ee;
    for (int k = 0; k < 8; k++) begin
      send(sels[k], imms[k]);
      ref_enc(sels[k], imms[k], ei, em, ee);
      n_checks++;
      if ({out_err, ImmOUT, out_mask} !== {ee, ei, em})
        $display("FAIL boundary_%0d: got %h expected %h", k, {out_err, ImmOUT, out_mask}, {ee, ei, em});
      else n_pass++;
      if (!ee) begin
        n_checks++;
        if (decode(sels[k], ImmOUT) !== imms[k])
          $display("FAIL boundary_roundtrip_%0d: got %h expected %h", k, decode(sels[k], ImmOUT), imms[k]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_errors();
    apply_reset();
    send(2'd0, 32'h0000_0800);
    n_checks++;
    if ({out_valid, out_err, ImmOUT, out_mask} !== {2'b11, 34'h0})
      $display("FAIL err_I_2048: got %h expected %h", {out_valid, out_err, ImmOUT, out_mask}, {2'b11, 34'h0});
    else n_pass++;
    send(2'd3, 32'h0);
    n_checks++;
    if ({out_valid, out_err, ImmOUT, out_mask} !== {2'b11, 34'h0})
      $display("FAIL err_sel3: got %h expected %h", {out_valid, out_err, ImmOUT, out_mask}, {2'b11, 34'h0});
    else n_pass++;
`ifdef IMMENC_ERRCNT_EN
    n_checks++;
    if (err_count !== 8'd2) $display("FAIL err_count_two: got %0d expected 2", err_count);
    else n_pass++;
    for (int k = 0; k < 260; k++) send(2'd3, $urandom);
    n_checks++;
    if (err_count !== 8'd255) $display("FAIL err_count_sat: got %0d expected 255", err_count);
    else n_pass++;
`endif
  endtask

  task automatic test_backpressure();
    logic [16:0] ei, em, ni, nm;
    logic ee, ne;
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid  = 1'b1;
    in_immsel = 2'd0;
    in_imm    = 32'h0000_05A5;
    out_ready = 1'b0;
    ref_enc(2'd0, 32'h0000_05A5, ei, em, ee);
    @(negedge clk);
    // Different request held at the input during the stall must not be taken.
    in_immsel = 2'd2;
    in_imm    = 32'h0000_0020;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_checks++;
      if (in_ready !== 1'b0) $display("FAIL stall_in_ready_%0d: got %b expected 0", k, in_ready);
      else n_pass++;
      @(negedge clk);
      n_checks++;
      if ({out_valid, out_err, ImmOUT, out_mask} !== {1'b1, ee, ei, em})
        $display("FAIL stall_hold_%0d: got %h expected %h", k, {out_valid, out_err, ImmOUT, out_mask}, {1'b1, ee, ei, em});
      else n_pass++;
    end
    out_ready = 1'b1;
    in_immsel = 2'd1;
    in_imm    = 32'hFFFF_FFFB;
    ref_enc(2'd1, 32'hFFFF_FFFB, ni, nm, ne);
    #1;
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL release_in_ready: got %b expected 1", in_ready);
    else n_pass++;
    @(negedge clk);
    in_valid = 1'b0;
    n_checks++;
    if ({out_valid, out_err, ImmOUT, out_mask} !== {1'b1, ne, ni, nm})
      $display("FAIL release_no_bubble: got %h expected %h", {out_valid, out_err, ImmOUT, out_mask}, {1'b1, ne, ni, nm});
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL drain_clears_valid: got %b expected 0", out_valid);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [1:0]  sels [4] = '{2'd0, 2'd1, 2'd2, 2'd0};
    logic [31:0] imms [4] = '{32'h0000_0123, 32'hFFFF_FF80, 32'h0000_0ABC, 32'hFFFF_F9F0};
    logic [16:0] ei, em;
    logic ee;
    out_ready = 1'b1;
    for (int k = 0; k <= 4; k++) begin
      @(negedge clk);
      if (k > 0) begin
        ref_enc(sels[k-1], imms[k-1], ei, em, ee);
        n_checks++;
        if ({out_valid, out_err, ImmOUT, out_mask} !== {1'b1, ee, ei, em})
          $display("FAIL b2b_%0d: got %h expected %h", k - 1, {out_valid, out_err, ImmOUT, out_mask}, {1'b1, ee, ei, em});
        else n_pass++;
      end
      if (k < 4) begin
        in_valid  = 1'b1;
        in_immsel = sels[k];
        in_imm    = imms[k];
      end else begin
        in_valid = 1'b0;
      end
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid  = 1'b1;
    in_immsel = 2'd1;
    in_imm    = 32'h0000_0123;
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1) $display("FAIL midreset_pending: got %b expected 1", out_valid);
    else n_pass++;
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({out_valid, out_err, ImmOUT, out_mask} !== 36'h0)
      $display("FAIL midreset_async_clear: got %h expected %h", {out_valid, out_err, ImmOUT, out_mask}, 36'h0);
    else n_pass++;
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL midreset_in_ready: got %b expected 1", in_ready);
    else n_pass++;
`ifdef IMMENC_ERRCNT_EN
    n_checks++;
    if (err_count !== 8'd0) $display("FAIL midreset_err_count: got %0d expected 0", err_count);
    else n_pass++;
`endif
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    m_vld  = 1'b0;
    m_imm  = '0;
    m_mask = '0;
    m_err  = 1'b0;
    m_cnt  = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b0) $display("FAIL midreset_no_output_%0d: got %b expected 0", k, out_valid);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    logic        exp_rdy;
    logic        pend = 1'b0;
    logic [1:0]  p_sel = 2'd0;
    logic [31:0] p_imm = '0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      n_checks++;
      if ({out_valid, out_err, ImmOUT, out_mask} !== {m_vld, m_err, m_imm, m_mask})
        $display("FAIL rand_out_%0d: got %h expected %h", i, {out_valid, out_err, ImmOUT, out_mask}, {m_vld, m_err, m_imm, m_mask});
      else n_pass++;
      if (pend && !m_err) begin
        n_checks++;
        if (decode(p_sel, ImmOUT) !== p_imm)
          $display("FAIL rand_roundtrip_%0d: got %h expected %h", i, decode(p_sel, ImmOUT), p_imm);
        else n_pass++;
      end
`ifdef IMMENC_ERRCNT_EN
      n_checks++;
      if (err_count !== 8'(m_cnt)) $display("FAIL rand_err_count_%0d: got %0d expected %0d", i, err_count, m_cnt);
      else n_pass++;
`endif
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      in_immsel = 2'($urandom_range(0, 3));
      in_imm    = rand_imm();
      exp_rdy   = !m_vld || out_ready;
      #1;
      n_checks++;
      if (in_ready !== exp_rdy) $display("FAIL rand_in_ready_%0d: got %b expected %b", i, in_ready, exp_rdy);
      else n_pass++;
      pend = 1'b0;
      if (in_valid && exp_rdy) begin
        ref_enc(in_immsel, in_imm, m_imm, m_mask, m_err);
        m_vld = 1'b1;
        if (m_err && m_cnt < 255) m_cnt++;
        pend  = 1'b1;
        p_sel = in_immsel;
        p_imm = in_imm;
      end else if (out_ready) begin
        m_vld = 1'b0;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_boundary();
    test_errors();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
